// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core.
// Default datapath width, reset vector and the bubble word used by every stage.
package mips_pkg;

  localparam int          DEF_WIDTH    = 32;
  localparam int          DEF_CNT_W    = 16;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
  // sll $0,$0,0: architecturally a no-op, so a bubble never changes machine state.
  localparam logic [31:0] DEF_NOP      = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JUMP   = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/decode controls and instruction memory in, IF/ID state out.
// The slave modport is the fetch stage; the master is its environment.
interface fetch_stage_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);

  logic             StallF;
  logic             StallD;
  logic             FlushD;
  logic             JumpD;
  logic [WIDTH-1:0] PCJumpD;
  logic             BranchD;
  logic [WIDTH-1:0] PCBranchD;
  logic [WIDTH-1:0] IMRD;
  logic [WIDTH-1:0] PCF;
  logic [WIDTH-1:0] InstrD;
  logic [WIDTH-1:0] PCPlus1D;
  logic             ValidD;
  logic [CNT_W-1:0] InstrCount;

  modport master (
    output StallF, StallD, FlushD, JumpD, PCJumpD, BranchD, PCBranchD, IMRD,
    input  PCF, InstrD, PCPlus1D, ValidD, InstrCount
  );

  modport slave (
    input  StallF, StallD, FlushD, JumpD, PCJumpD, BranchD, PCBranchD, IMRD,
    output PCF, InstrD, PCPlus1D, ValidD, InstrCount
  );

endinterface

// File: rtl/pipeline_register.sv
// Generic pipeline register: async reset and synchronous clear both load CLR_VAL.
// A deasserted enable holds the contents and also blocks the clear.
module pipeline_register #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  // NOTE: clocked state uses <= so every register samples pre-edge values in parallel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= CLR_VAL;
    end else if (i_en) begin
      if (i_clr) begin
        r_q <= CLR_VAL;
      end else begin
        r_q <= i_d;
      end
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC select, IF/ID register and a
// saturating count of instructions handed to decode.
module fetch_stage
  import mips_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [WIDTH-1:0] NOP      = DEF_NOP,
  parameter int               CNT_W    = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  bus
);

  localparam int               IFID_W   = 2 * WIDTH + 1;
  localparam logic [IFID_W-1:0] IFID_CLR = {1'b0, {WIDTH{1'b0}}, NOP};

  pc_sel_e          w_pc_sel;
  logic [WIDTH-1:0] w_pc_plus1;
  logic [WIDTH-1:0] w_pc_next;
  logic [WIDTH-1:0] r_pc;

  // Sequential address wraps naturally modulo 2^WIDTH.
  assign w_pc_plus1 = r_pc + 1'b1;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_pc_sel = PC_SEQ;
    if (bus.JumpD) begin
      w_pc_sel = PC_JUMP;
    end else if (bus.BranchD) begin
      w_pc_sel = PC_BRANCH;
    end
  end

  always_comb begin
    w_pc_next = w_pc_plus1;
    case (w_pc_sel)
      PC_JUMP:   w_pc_next = bus.PCJumpD;
      PC_BRANCH: w_pc_next = bus.PCBranchD;
      default:   w_pc_next = w_pc_plus1;
    endcase
  end

  // StallF freezes the PC even with a redirect pending; the hazard unit re-presents it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= RESET_PC;
    end else if (!bus.StallF) begin
      r_pc <= w_pc_next;
    end
  end

  logic              w_ifid_en;
  logic              w_ifid_load;
  logic [IFID_W-1:0] w_ifid_d;
  logic [IFID_W-1:0] w_ifid_q;

  assign w_ifid_en   = !bus.StallD;
  assign w_ifid_load = !bus.StallD && !bus.FlushD;
  assign w_ifid_d    = {1'b1, w_pc_plus1, bus.IMRD};

  pipeline_register #(
    .WIDTH   (IFID_W),
    .CLR_VAL (IFID_CLR)
  ) u_if_id (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_ifid_en),
    .i_clr (bus.FlushD),
    .i_d   (w_ifid_d),
    .o_q   (w_ifid_q)
  );

  logic [CNT_W-1:0] r_instr_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr_count <= '0;
    end else if (w_ifid_load && (r_instr_count != {CNT_W{1'b1}})) begin
      r_instr_count <= r_instr_count + 1'b1;
    end
  end

  assign bus.PCF        = r_pc;
  assign bus.ValidD     = w_ifid_q[IFID_W-1];
  assign bus.PCPlus1D   = w_ifid_q[2*WIDTH-1:WIDTH];
  assign bus.InstrD     = w_ifid_q[WIDTH-1:0];
  assign bus.InstrCount = r_instr_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, corner sequences,
// randomized traffic against a behavioural model, and a 2-bit counter instance.
module tb_fetch_stage;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic reset_s = 1'b1;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mem [64];

  fetch_stage_if #(.WIDTH(32), .CNT_W(16)) bus ();
  fetch_stage_if #(.WIDTH(32), .CNT_W(2))  bus_s ();

  assign bus.IMRD   = mem[bus.PCF[5:0]];
  assign bus_s.IMRD = mem[bus_s.PCF[5:0]];
  assign bus_s.StallF = 1'b0;
  assign bus_s.StallD = 1'b0;
  assign bus_s.FlushD = 1'b0;
  assign bus_s.JumpD = 1'b0;
  assign bus_s.BranchD = 1'b0;
  assign bus_s.PCJumpD = '0;
  assign bus_s.PCBranchD = '0;

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .NOP(32'h0), .CNT_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_stage #(.WIDTH(32), .RESET_PC(32'h0), .NOP(32'h0), .CNT_W(2)) dut_s (
    .clk   (clk),
    .reset (reset_s),
    .bus   (bus_s)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Behavioural model: the architectural state of the stage as plain variables.
  logic [31:0] m_pc, m_instr, m_pcp1;
  logic        m_valid;
  int          m_cnt;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pcp1 = 32'h0; m_valid = 1'b0; m_cnt = 0;
  endtask

  task automatic model_edge();
    logic [31:0] fetched;
    logic [31:0] target;
    fetched = mem[m_pc[5:0]];
    if (bus.JumpD) target = bus.PCJumpD;
    else if (bus.BranchD) target = bus.PCBranchD;
    else target = m_pc + 32'd1;
    if (!bus.StallD) begin
      if (bus.FlushD) begin
        m_instr = 32'h0; m_pcp1 = 32'h0; m_valid = 1'b0;
      end else begin
        m_instr = fetched; m_pcp1 = m_pc + 32'd1; m_valid = 1'b1;
        if (m_cnt < 65535) m_cnt++;
      end
    end
    if (!bus.StallF) m_pc = target;
  endtask

  task automatic drive(input logic sf, input logic sd, input logic fd,
                       input logic j, input logic [31:0] jt,
                       input logic b, input logic [31:0] bt);
    bus.StallF = sf; bus.StallD = sd; bus.FlushD = fd;
    bus.JumpD = j; bus.PCJumpD = jt; bus.BranchD = b; bus.PCBranchD = bt;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".PCF"},        bus.PCF,               m_pc);
    check({tag, ".InstrD"},     bus.InstrD,            m_instr);
    check({tag, ".PCPlus1D"},   bus.PCPlus1D,          m_pcp1);
    check({tag, ".ValidD"},     32'(bus.ValidD),       32'(m_valid));
    check({tag, ".InstrCount"}, 32'(bus.InstrCount),   32'(m_cnt));
  endtask

  typedef struct {
    logic        sf, sd, fd, j, b;
    logic [31:0] jt, bt;
    logic [31:0] e_pc, e_instr, e_pcp1;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t v(input logic sf, input logic sd, input logic fd,
                             input logic j, input logic [31:0] jt,
                             input logic b, input logic [31:0] bt,
                             input logic [31:0] e_pc, input logic [31:0] e_instr,
                             input logic [31:0] e_pcp1, input logic e_valid,
                             input logic [15:0] e_cnt);
    vec_t r;
    r.sf = sf; r.sd = sd; r.fd = fd; r.j = j; r.jt = jt; r.b = b; r.bt = bt;
    r.e_pc = e_pc; r.e_instr = e_instr; r.e_pcp1 = e_pcp1;
    r.e_valid = e_valid; r.e_cnt = e_cnt;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;

    //        sf sd fd j  jt   b  bt   e_pc  e_instr  e_pcp1 v  cnt
    tbl[0]  = v(0, 0, 0, 0, 0,  0, 0,  1,  mem[0],  1,  1, 1);
    tbl[1]  = v(0, 0, 0, 0, 0,  0, 0,  2,  mem[1],  2,  1, 2);
    tbl[2]  = v(0, 0, 0, 0, 0,  0, 0,  3,  mem[2],  3,  1, 3);
    tbl[3]  = v(0, 0, 0, 0, 0,  0, 0,  4,  mem[3],  4,  1, 4);
    tbl[4]  = v(1, 1, 0, 0, 0,  0, 0,  4,  mem[3],  4,  1, 4);
    tbl[5]  = v(1, 1, 0, 0, 0,  0, 0,  4,  mem[3],  4,  1, 4);
    tbl[6]  = v(1, 1, 0, 0, 0,  0, 0,  4,  mem[3],  4,  1, 4);
    tbl[7]  = v(0, 0, 0, 0, 0,  0, 0,  5,  mem[4],  5,  1, 5);
    tbl[8]  = v(0, 0, 0, 0, 0,  0, 0,  6,  mem[5],  6,  1, 6);
    tbl[9]  = v(0, 0, 0, 0, 0,  0, 0,  7,  mem[6],  7,  1, 7);
    tbl[10] = v(0, 0, 1, 1, 20, 0, 0,  20, 32'h0,   0,  0, 7);
    tbl[11] = v(0, 0, 0, 0, 0,  0, 0,  21, mem[20], 21, 1, 8);
    tbl[12] = v(0, 0, 1, 1, 8,  1, 12, 8,  32'h0,   0,  0, 8);
    tbl[13] = v(1, 0, 0, 0, 0,  1, 12, 8,  mem[8],  9,  1, 9);
    tbl[14] = v(0, 1, 1, 0, 0,  0, 0,  9,  mem[8],  9,  1, 9);
    tbl[15] = v(0, 0, 0, 0, 0,  0, 0,  10, mem[9],  10, 1, 10);
    tbl[16] = v(0, 0, 1, 0, 0,  0, 0,  11, 32'h0,   0,  0, 10);
    tbl[17] = v(0, 1, 1, 0, 0,  0, 0,  12, 32'h0,   0,  0, 10);
    tbl[18] = v(0, 0, 0, 0, 0,  0, 0,  13, mem[12], 13, 1, 11);

    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    check("reset.PCF",        bus.PCF,             32'h0);
    check("reset.InstrD",     bus.InstrD,          32'h0);
    check("reset.PCPlus1D",   bus.PCPlus1D,        32'h0);
    check("reset.ValidD",     32'(bus.ValidD),     32'h0);
    check("reset.InstrCount", 32'(bus.InstrCount), 32'h0);
    reset = 1'b0;
    model_reset();

    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].sf, tbl[i].sd, tbl[i].fd, tbl[i].j, tbl[i].jt, tbl[i].b, tbl[i].bt);
      step();
      check($sformatf("vec%0d.PCF", i),        bus.PCF,             tbl[i].e_pc);
      check($sformatf("vec%0d.InstrD", i),     bus.InstrD,          tbl[i].e_instr);
      check($sformatf("vec%0d.PCPlus1D", i),   bus.PCPlus1D,        tbl[i].e_pcp1);
      check($sformatf("vec%0d.ValidD", i),     32'(bus.ValidD),     32'(tbl[i].e_valid));
      check($sformatf("vec%0d.InstrCount", i), 32'(bus.InstrCount), 32'(tbl[i].e_cnt));
    end

    // PC wrap from all-ones back to zero.
    drive(0, 0, 1, 1, 32'hFFFF_FFFF, 0, 0);
    step();
    check("wrap.PCF_top", bus.PCF, 32'hFFFF_FFFF);
    drive(0, 0, 0, 0, 0, 0, 0);
    step();
    check("wrap.PCF_zero",   bus.PCF,      32'h0);
    check("wrap.PCPlus1D",   bus.PCPlus1D, 32'h0);
    check("wrap.InstrD",     bus.InstrD,   mem[63]);
    check("wrap.InstrCount", 32'(bus.InstrCount), 32'd12);

    // Asynchronous reset in the middle of a stall with a redirect pending.
    drive(1, 1, 0, 0, 0, 1, 40);
    step();
    #3;
    reset = 1'b1;
    #1;
    check("midreset.PCF",        bus.PCF,             32'h0);
    check("midreset.InstrD",     bus.InstrD,          32'h0);
    check("midreset.ValidD",     32'(bus.ValidD),     32'h0);
    check("midreset.InstrCount", 32'(bus.InstrCount), 32'h0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    reset = 1'b0;
    model_reset();
    step();
    check("restart.PCF",        bus.PCF,             32'h1);
    check("restart.InstrD",     bus.InstrD,          32'h2008_0005);
    check("restart.PCPlus1D",   bus.PCPlus1D,        32'h1);
    check("restart.InstrCount", 32'(bus.InstrCount), 32'h1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] jt;
      jt = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 63));
      drive(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 7) == 0), jt,
            ($urandom_range(0, 7) == 0), 32'($urandom_range(0, 63)));
      step();
      check_model($sformatf("rand%0d", i));
    end

    // Small counter instance: saturates at 3, then async reset between edges.
    @(posedge clk);
    #2;
    reset_s = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      check($sformatf("sat%0d.InstrCount", i), 32'(bus_s.InstrCount), (i < 3) ? 32'(i + 1) : 32'd3);
      check($sformatf("sat%0d.PCF", i),        bus_s.PCF,             32'(i + 1));
    end
    #2;
    reset_s = 1'b1;
    #1;
    check("sat_reset.PCF",        bus_s.PCF,             32'h0);
    check("sat_reset.InstrCount", 32'(bus_s.InstrCount), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
